// File: rtl/sample_stash.sv
// Circular stash of the most recent DEPTH samples; new samples are shown immediately,
// and browse pulses step the registered output forward through the stored entries.
module sample_stash #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    input  logic             next_sample,
    output logic [WIDTH-1:0] sample_out
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    wr_inc, rd_inc;

    always_comb begin
        wr_inc   = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        rd_inc   = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;
        // Store takes priority over browse; a store also parks the read pointer on the new entry.
        if (sample_in_valid) begin
            wr_ptr_d = wr_inc;
            rd_ptr_d = wr_ptr_q;
            out_d    = sample_in;
        end else if (next_sample) begin
            rd_ptr_d = rd_inc;
            out_d    = mem_q[rd_inc];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            out_q    <= '0;
        end else begin
            if (sample_in_valid) begin
                mem_q[wr_ptr_q] <= sample_in;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            out_q    <= out_d;
        end
    end

    assign sample_out = out_q;

endmodule

// File: tb/tb_sample_stash.sv
// Directed bench for sample_stash: expected displays are queued as each step is driven
// and popped for comparison one time unit after the capturing clock edge.
module tb_sample_stash;

    logic       clk;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_in_valid;
    logic       next_sample;
    logic [7:0] sample_out;

    int unsigned vectors;
    int unsigned miscompares;
    logic [7:0]  sb [$];

    sample_stash #(.DEPTH(5), .WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .next_sample     (next_sample),
        .sample_out      (sample_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag);
        logic [7:0] exp;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, sample_out);
        end else begin
            exp = sb.pop_front();
            assert (sample_out === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, sample_out, exp);
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic n,
                        input logic [7:0] exp, input string tag);
        sample_in_valid = v;
        sample_in       = d;
        next_sample     = n;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        compare(tag);
        sample_in_valid = 1'b0;
        next_sample     = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b0;
        sample_in       = '0;
        sample_in_valid = 1'b0;
        next_sample     = 1'b0;

        #3;
        sb.push_back(8'h00);
        compare("reset_state");
        @(negedge clk);
        reset = 1'b1;

        // Streaming store 0..6
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'(i), 1'b0, 8'(i), "stream");
        end

        // Asynchronous reset with nonzero data stored
        #2;
        reset = 1'b0;
        #1;
        sb.push_back(8'h00);
        compare("async_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hFF, 1'b1, 8'h00, "post_reset_browse");
        end

        // Partial fill then browse
        pulse_reset();
        step(1'b1, 8'h11, 1'b0, 8'h11, "fill");
        step(1'b1, 8'h22, 1'b0, 8'h22, "fill");
        step(1'b1, 8'h33, 1'b0, 8'h33, "fill");
        step(1'b0, 8'h00, 1'b1, 8'h00, "partial_browse");
        step(1'b0, 8'h00, 1'b1, 8'h00, "partial_browse");
        step(1'b0, 8'h00, 1'b1, 8'h11, "partial_browse");
        step(1'b0, 8'h00, 1'b1, 8'h22, "partial_browse");
        step(1'b0, 8'h00, 1'b1, 8'h33, "partial_browse");

        // Wrap and overwrite
        pulse_reset();
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 8'(i), 1'b0, 8'(i), "wrap_store");
        end
        for (int i = 3; i <= 7; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(i), "wrap_browse");
        end

        // Store wins over simultaneous browse; next browse shows entry after the A5 slot
        step(1'b1, 8'hA5, 1'b1, 8'hA5, "simultaneous");
        step(1'b0, 8'h00, 1'b1, 8'h04, "after_simul");

        // Hold with changing but invalid data on the input
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'(8'h5A + i), 1'b0, 8'h04, "hold");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
